oled_spi_arbiter: RTL and testbench

Shares the single N-byte MOSI SPI buffer of the SSD1331 OLED interface between two packet requesters: requester 0 is the power-on/command sequencer, requester 1 is the pixel/drawing engine. The arbiter picks one requester and latches its packet. It then drives the buffer's load port, waits for end-of-transfer, enforces an inter-packet gap, and reports completion or timeout. It runs on the system clock and sits between the requesters and the buffer/clock-divider pair.

---
 rtl/oled_spi_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_oled_spi_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_arbiter.sv
// ---------------------------------------------------------------------------
// oled_spi_arbiter
//   Shares the single N-byte MOSI SPI buffer of the SSD1331 OLED interface
//   between two packet requesters (0 = command sequencer, 1 = pixel engine).
//   A winner is picked in IDLE, its packet is latched into the o_BUF_*
//   registers, the buffer load strobe is held for START_HOLD cycles, then the
//   arbiter waits for the buffer's end-of-transfer flag (or a timeout) and
//   finally enforces an idle gap of GAP_CYCLES before the next grant.
//
//   Configuration macro: OLED_ARB_RR_EN
//     defined   -> round-robin between simultaneous requests
//     undefined -> fixed priority, requester 0 always wins
//
//   Ports:
//     i_CLK, i_RST            system clock, async active-low reset
//     i_REQ[1:0]              request levels
//     i_DATA0/1, i_DC0/1,     per-requester packet bytes, D/C flags and
//     i_NT0/1                 byte count
//     o_GNT[1:0]              one-hot grant pulse
//     o_DONE[1:0]             completion pulse to the served requester
//     o_ERR                   timeout pulse
//     o_BUSY                  high whenever not IDLE
//     o_BUF_DATA/DC/NT        latched packet towards the buffer
//     o_BUF_START             buffer load strobe
//     i_BUF_DONE              buffer final-bit flag (SCK domain)
// ---------------------------------------------------------------------------
module oled_spi_arbiter #(
   parameter int WIDTH      = 8,
   parameter int N          = 8,
   parameter int START_HOLD = 20,
   parameter int GAP_CYCLES = 40,
   parameter int TIMEOUT    = 2000
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic [1:0]           i_REQ,
   input  logic [WIDTH*N-1:0]   i_DATA0,
   input  logic [WIDTH*N-1:0]   i_DATA1,
   input  logic [N-1:0]         i_DC0,
   input  logic [N-1:0]         i_DC1,
   input  logic [4:0]           i_NT0,
   input  logic [4:0]           i_NT1,
   output logic [1:0]           o_GNT,
   output logic [1:0]           o_DONE,
   output logic                 o_ERR,
   output logic                 o_BUSY,
   output logic [WIDTH*N-1:0]   o_BUF_DATA,
   output logic [N-1:0]         o_BUF_DC,
   output logic [4:0]           o_BUF_NT,
   output logic                 o_BUF_START,
   input  logic                 i_BUF_DONE
);

   localparam int MAX_A = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int MAX_C = (MAX_A > START_HOLD) ? MAX_A : START_HOLD;
   localparam int CNT_W = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   // Counts above N are clamped so the buffer never shifts past its end.
   function automatic logic [4:0] clamp_nt(input logic [4:0] nt);
      if (nt > 5'(N)) begin
         return 5'(N);
      end else begin
         return nt;
      end
   endfunction

   logic [2:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                winner_q, winner_d;
   logic                win_s;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          done_q, done_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                start_q, start_d;
   logic [WIDTH*N-1:0]  data_q, data_d;
   logic [N-1:0]        dc_q, dc_d;
   logic [4:0]          nt_q, nt_d;
   logic [2:0]          sync_q;
   logic                done_rise_s;

   // Stage 0/1 resynchronise the SCK-domain flag, stage 2 is the edge history.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], i_BUF_DONE};
      end
   end

   assign done_rise_s = sync_q[1] & ~sync_q[2];

`ifdef OLED_ARB_RR_EN
   logic last_q;

   // Remember the last served requester; reset value lets requester 0 win first.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         last_q <= 1'b1;
      end else if ((state_q == S_IDLE) && (i_REQ != 2'b00)) begin
         last_q <= win_s;
      end else begin
         last_q <= last_q;
      end
   end

   // Round-robin winner: on a tie the requester not served last wins.
   always_comb begin
      if (i_REQ == 2'b11) begin
         win_s = ~last_q;
      end else if (i_REQ[0]) begin
         win_s = 1'b0;
      end else begin
         win_s = 1'b1;
      end
   end
`else
   // Fixed priority winner: requester 0 always wins a tie.
   always_comb begin
      if (i_REQ[0]) begin
         win_s = 1'b0;
      end else begin
         win_s = 1'b1;
      end
   end
`endif

   // Next-state and registered-output computation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      winner_d = winner_q;
      gnt_d    = 2'b00;
      done_d   = 2'b00;
      err_d    = 1'b0;
      start_d  = 1'b0;
      data_d   = data_q;
      dc_d     = dc_q;
      nt_d     = nt_q;
      case (state_q)
         S_IDLE: begin
            if (i_REQ != 2'b00) begin
               state_d  = S_GRANT;
               cnt_d    = '0;
               winner_d = win_s;
               gnt_d    = win_s ? 2'b10 : 2'b01;
               data_d   = win_s ? i_DATA1 : i_DATA0;
               dc_d     = win_s ? i_DC1 : i_DC0;
               nt_d     = clamp_nt(win_s ? i_NT1 : i_NT0);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            cnt_d = '0;
            if (nt_q == 5'd0) begin
               // Empty packet: complete immediately without touching the buffer.
               done_d[winner_q] = 1'b1;
               state_d          = S_GAP;
            end else begin
               start_d = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               start_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (done_rise_s) begin
               done_d[winner_q] = 1'b1;
               cnt_d            = '0;
               state_d          = S_GAP;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, counter and output registers; reset aborts any transfer silently.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         winner_q <= 1'b0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         data_q   <= '0;
         dc_q     <= '0;
         nt_q     <= 5'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         winner_q <= winner_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         start_q  <= start_d;
         data_q   <= data_d;
         dc_q     <= dc_d;
         nt_q     <= nt_d;
      end
   end

   assign o_GNT       = gnt_q;
   assign o_DONE      = done_q;
   assign o_ERR       = err_q;
   assign o_BUSY      = busy_q;
   assign o_BUF_START = start_q;
   assign o_BUF_DATA  = data_q;
   assign o_BUF_DC    = dc_q;
   assign o_BUF_NT    = nt_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oled_spi_arbiter
//   Directed bench for oled_spi_arbiter: a vector table of single packets
//   plus hand-written sequences for arbitration order, timeout, reset during
//   a transfer and a stray buffer-done flag during the gap. Expectations
//   follow OLED_ARB_RR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_oled_spi_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [63:0] d0, d1;
   logic [7:0]  dc0, dc1;
   logic [4:0]  nt0, nt1;
   logic [1:0]  gnt, done;
   logic        err, busy, bstart, bdone;
   logic [63:0] bdata;
   logic [7:0]  bdc;
   logic [4:0]  bnt;

   int n_cmp  = 0;
   int n_fail = 0;

   oled_spi_arbiter dut (
      .i_CLK(clk), .i_RST(rst_n), .i_REQ(req),
      .i_DATA0(d0), .i_DATA1(d1), .i_DC0(dc0), .i_DC1(dc1),
      .i_NT0(nt0), .i_NT1(nt1),
      .o_GNT(gnt), .o_DONE(done), .o_ERR(err), .o_BUSY(busy),
      .o_BUF_DATA(bdata), .o_BUF_DC(bdc), .o_BUF_NT(bnt),
      .o_BUF_START(bstart), .i_BUF_DONE(bdone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  req;
      logic [63:0] d0;
      logic [7:0]  dc0;
      logic [4:0]  nt0;
      logic [63:0] d1;
      logic [7:0]  dc1;
      logic [4:0]  nt1;
      logic [1:0]  egnt;
      logic [63:0] edata;
      logic [7:0]  edc;
      logic [4:0]  ent;
   } vec_t;

   vec_t vt[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_gnt(output logic [1:0] g);
      g = 2'b00;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (gnt != 2'b00) begin
            g = gnt;
            break;
         end
      end
   endtask

   // Counts o_BUF_START high cycles; returns on the first cycle it is low.
   task automatic count_start(output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (bstart) n++;
         else break;
      end
   endtask

   task automatic pulse_done(output int lat, output logic [1:0] d);
      bdone = 1'b1;
      lat = 0;
      d = 2'b00;
      for (int k = 0; k < 10; k++) begin
         tick();
         lat++;
         if (done != 2'b00) begin
            d = done;
            break;
         end
      end
      bdone = 1'b0;
   endtask

   // Cycles until o_BUSY drops; counts stray DONE/ERR pulses seen meanwhile.
   task automatic wait_idle(input bit inject, output int n, output int extra);
      n = 0;
      extra = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         n++;
         if (done != 2'b00 || err) extra++;
         if (inject && k == 5) bdone = 1'b1;
         if (inject && k == 8) bdone = 1'b0;
         if (!busy) break;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},   64'(gnt), 64'd0);
      check({tag, "_done"},  64'(done), 64'd0);
      check({tag, "_err"},   64'(err), 64'd0);
      check({tag, "_busy"},  64'(busy), 64'd0);
      check({tag, "_start"}, 64'(bstart), 64'd0);
      check({tag, "_data"},  bdata, 64'd0);
      check({tag, "_dc"},    64'(bdc), 64'd0);
      check({tag, "_nt"},    64'(bnt), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [1:0] g, d;
   logic [1:0] alt_exp[4];
   int n, lat, extra, dseen;

   initial begin
      rst_n = 1'b0; req = 2'b00; bdone = 1'b0;
      d0 = 64'd0; d1 = 64'd0; dc0 = 8'd0; dc1 = 8'd0; nt0 = 5'd0; nt1 = 5'd0;

      vt[0] = '{2'b01, 64'h00000000000000AF, 8'h00, 5'd1,
                64'h1111111111111111, 8'hFF, 5'd3,
                2'b01, 64'h00000000000000AF, 8'h00, 5'd1};
      vt[1] = '{2'b10, 64'h2222222222222222, 8'h11, 5'd2,
                64'h0123456789ABCDEF, 8'hA5, 5'd12,
                2'b10, 64'h0123456789ABCDEF, 8'hA5, 5'd8};
      vt[2] = '{2'b01, 64'hDEADBEEFCAFEF00D, 8'h3C, 5'd0,
                64'h3333333333333333, 8'h77, 5'd4,
                2'b01, 64'hDEADBEEFCAFEF00D, 8'h3C, 5'd0};
`ifdef OLED_ARB_RR_EN
      vt[3] = '{2'b11, 64'h5555555555555555, 8'h0F, 5'd4,
                64'hAAAAAAAAAAAAAAAA, 8'hF0, 5'd8,
                2'b10, 64'hAAAAAAAAAAAAAAAA, 8'hF0, 5'd8};
      alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      vt[3] = '{2'b11, 64'h5555555555555555, 8'h0F, 5'd4,
                64'hAAAAAAAAAAAAAAAA, 8'hF0, 5'd8,
                2'b01, 64'h5555555555555555, 8'h0F, 5'd4};
      alt_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      check("idle_after_reset_busy", 64'(busy), 64'd0);

      // Table-driven single packets
      for (int i = 0; i < 4; i++) begin
         d0 = vt[i].d0; dc0 = vt[i].dc0; nt0 = vt[i].nt0;
         d1 = vt[i].d1; dc1 = vt[i].dc1; nt1 = vt[i].nt1;
         req = vt[i].req;
         wait_gnt(g);
         check($sformatf("v%0d_gnt", i), 64'(g), 64'(vt[i].egnt));
         check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
         check($sformatf("v%0d_data", i), bdata, vt[i].edata);
         check($sformatf("v%0d_dc", i), 64'(bdc), 64'(vt[i].edc));
         check($sformatf("v%0d_nt", i), 64'(bnt), 64'(vt[i].ent));
         // Payload may change right after the grant
         req = 2'b00;
         d0 = ~vt[i].d0; d1 = ~vt[i].d1; nt0 = 5'd31; nt1 = 5'd31;
         if (vt[i].ent == 5'd0) begin
            tick();
            check($sformatf("v%0d_done_nt0", i), 64'(done), 64'(vt[i].egnt));
            check($sformatf("v%0d_nostart", i), 64'(bstart), 64'd0);
         end else begin
            count_start(n);
            check($sformatf("v%0d_start_len", i), 64'(n), 64'd20);
            pulse_done(lat, d);
            check($sformatf("v%0d_done_lat", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_done", i), 64'(d), 64'(vt[i].egnt));
         end
         wait_idle(1'b0, n, extra);
         check($sformatf("v%0d_gap", i), 64'(n), 64'd40);
         check($sformatf("v%0d_extra", i), 64'(extra), 64'd0);
         check($sformatf("v%0d_hold", i), bdata, vt[i].edata);
      end

      // Both requesters held high continuously
      do_reset();
      d0 = 64'h0000000000000011; nt0 = 5'd1; dc0 = 8'h00;
      d1 = 64'h0000000000000022; nt1 = 5'd1; dc1 = 8'h01;
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(g);
         check($sformatf("alt%0d_gnt", i), 64'(g), 64'(alt_exp[i]));
         count_start(n);
         pulse_done(lat, d);
         check($sformatf("alt%0d_done", i), 64'(d), 64'(alt_exp[i]));
         wait_idle(1'b0, n, extra);
      end
      req = 2'b00;

      // Stray buffer-done during the gap
      d0 = 64'h0000000000000044; nt0 = 5'd1;
      req = 2'b01;
      wait_gnt(g);
      req = 2'b00;
      check("gapinj_gnt", 64'(g), 64'd1);
      count_start(n);
      pulse_done(lat, d);
      check("gapinj_done", 64'(d), 64'd1);
      wait_idle(1'b1, n, extra);
      check("gapinj_extra", 64'(extra), 64'd0);
      check("gapinj_gap", 64'(n), 64'd40);
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done != 2'b00) extra++;
      end
      check("gapinj_after", 64'(extra), 64'd0);

      // Timeout: buffer never signals completion
      d0 = 64'h0000000000000055; nt0 = 5'd2;
      req = 2'b01;
      wait_gnt(g);
      req = 2'b00;
      check("to_gnt", 64'(g), 64'd1);
      count_start(n);
      check("to_start_len", 64'(n), 64'd20);
      n = 0;
      dseen = 0;
      for (int k = 0; k < 3000; k++) begin
         tick();
         n++;
         if (done != 2'b00) dseen++;
         if (err) break;
      end
      check("to_err_lat", 64'(n), 64'd2000);
      check("to_err", 64'(err), 64'd1);
      check("to_nodone", 64'(dseen), 64'd0);
      wait_idle(1'b0, n, extra);
      check("to_gap", 64'(n), 64'd40);
      check("to_extra", 64'(extra), 64'd0);

      // Reset while waiting for the buffer
      d0 = 64'h0000000000000066; nt0 = 5'd3;
      req = 2'b01;
      wait_gnt(g);
      req = 2'b00;
      count_start(n);
      for (int k = 0; k < 5; k++) tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      d1 = 64'h0000000000000077; nt1 = 5'd5; dc1 = 8'h1F;
      req = 2'b10;
      tick();
      tick();
      tick();
      rst_n = 1'b1;
      wait_gnt(g);
      req = 2'b00;
      check("postrst_gnt", 64'(g), 64'd2);
      check("postrst_nt", 64'(bnt), 64'd5);
      check("postrst_data", bdata, 64'h0000000000000077);
      count_start(n);
      check("postrst_start_len", 64'(n), 64'd20);
      pulse_done(lat, d);
      check("postrst_done_lat", 64'(lat), 64'd3);
      check("postrst_done", 64'(d), 64'd2);
      wait_idle(1'b0, n, extra);
      check("postrst_gap", 64'(n), 64'd40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
